// File: rtl/clkbuf_enable_sequencer.sv
// clkbuf_enable_sequencer: walks clock-branch enables toward a request one bit at a time with a quiet gap
module clkbuf_enable_sequencer #(
  parameter int N   = 4,
  parameter int GAP = 3
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic [N-1:0] REQ,
  input  logic         HOLD,
  output logic [N-1:0] EN,
  output logic         BUSY,
  output logic         DONE
);
  localparam int CW = $clog2(GAP + 1);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [N-1:0] dis, ena, cand, pick;
  // disables outrank enables; the lowest set bit of the winning class is isolated
  always_comb begin
    dis  = EN & ~REQ;
    ena  = ~EN & REQ;
    cand = |dis ? dis : ena;
    pick = cand & (-cand);
  end
  assign BUSY = (state == S_WAIT) | (REQ != EN);
  // toggle one branch from idle, then hold every enable frozen for the quiet gap
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      cnt   <= '0;
      EN    <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == S_IDLE) begin
        if (!HOLD && REQ != EN) begin
          EN    <= EN ^ pick;
          cnt   <= CW'(GAP);
          state <= S_WAIT;
        end
      end else if (cnt == CW'(1)) begin
        state <= S_IDLE;
        DONE  <= (REQ == EN);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_clkbuf_enable_sequencer.sv
// tb_clkbuf_enable_sequencer: directed scenarios checked against an edge-counting model of the sequencer
module tb_clkbuf_enable_sequencer;
  localparam int GAP = 3;
  logic CLK = 1'b0;
  logic RN = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic HOLD = 1'b0;
  logic [3:0] EN;
  logic BUSY, DONE;
  int checks = 0;
  int errors = 0;
  int e, lt;
  logic [3:0] men;
  logic mdone;

  clkbuf_enable_sequencer #(.N(4), .GAP(GAP)) dut (
    .CLK(CLK), .RN(RN), .REQ(REQ), .HOLD(HOLD), .EN(EN), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // a disable is chosen before any enable, lowest index first
  function automatic logic [3:0] sel(input logic [3:0] en, input logic [3:0] req);
    for (int i = 0; i < 4; i++) if (en[i] && !req[i]) return 4'(1 << i);
    for (int i = 0; i < 4; i++) if (!en[i] && req[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  // model: e counts edges since reset, lt is the edge of the last toggle;
  // toggles need GAP+1 edges of spacing and the gap ends GAP edges after a toggle
  always @(posedge CLK or negedge RN) begin
    if (!RN) begin
      e     <= 0;
      lt    <= -100;
      men   <= 4'b0000;
      mdone <= 1'b0;
    end else begin
      e     <= e + 1;
      mdone <= (e + 1 - lt == GAP) && (REQ == men);
      if ((e + 1 - lt >= GAP + 1) && !HOLD && REQ != men) begin
        men <= men ^ sel(men, REQ);
        lt  <= e + 1;
      end
    end
  end

  // every falling edge: outputs against the model
  always @(negedge CLK) begin
    checks += 3;
    if (EN !== men) begin
      errors++;
      $display("FAIL model_en t=%0t got %b expected %b", $time, EN, men);
    end
    if (DONE !== mdone) begin
      errors++;
      $display("FAIL model_done t=%0t got %b expected %b", $time, DONE, mdone);
    end
    if (BUSY !== ((e - lt < GAP) || (REQ != men))) begin
      errors++;
      $display("FAIL model_busy t=%0t got %b expected %b", $time, BUSY, (e - lt < GAP) || (REQ != men));
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic do_reset();
    RN = 1'b0;
    #1;
    lit("reset_en", int'(EN), 0);
    lit("reset_done", int'(DONE), 0);
    #1;
    RN = 1'b1;
  endtask

  initial begin
    tick(1);
    // full power-up
    REQ = 4'b1111;
    do_reset();
    lit("reset_busy", int'(BUSY), 1);
    tick(1);  lit("pu_e1", int'(EN), 4'b0001);
    tick(4);  lit("pu_e5", int'(EN), 4'b0011);
    tick(4);  lit("pu_e9", int'(EN), 4'b0111);
    tick(4);  lit("pu_e13", int'(EN), 4'b1111);
    lit("pu_done_early", int'(DONE), 0);
    tick(3);  lit("pu_done", int'(DONE), 1);
    lit("pu_busy", int'(BUSY), 0);
    tick(1);  lit("pu_done_clr", int'(DONE), 0);
    // disable priority
    REQ = 4'b0011;
    do_reset();
    tick(8);  lit("dp_setup", int'(EN), 4'b0011);
    REQ = 4'b1100;
    tick(1);  lit("dp_t1", int'(EN), 4'b0010);
    tick(4);  lit("dp_t2", int'(EN), 4'b0000);
    tick(4);  lit("dp_t3", int'(EN), 4'b0100);
    tick(4);  lit("dp_t4", int'(EN), 4'b1100);
    tick(3);  lit("dp_done", int'(DONE), 1);
    tick(1);  lit("dp_done_clr", int'(DONE), 0);
    // request reverts during the gap
    REQ = 4'b0011;
    do_reset();
    tick(1);  lit("rv_t1", int'(EN), 4'b0001);
    REQ = 4'b0001;
    tick(3);  lit("rv_done", int'(DONE), 1);
    tick(6);  lit("rv_en", int'(EN), 4'b0001);
    lit("rv_done_clr", int'(DONE), 0);
    // hold in idle
    REQ = 4'b0000;
    do_reset();
    tick(2);
    HOLD = 1'b1;
    REQ = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      lit("hold_en", int'(EN), 0);
      lit("hold_busy", int'(BUSY), 1);
    end
    HOLD = 1'b0;
    tick(1);  lit("hold_rel", int'(EN), 4'b0001);
    tick(3);  lit("hold_done", int'(DONE), 1);
    // reset mid-sequence
    REQ = 4'b1111;
    do_reset();
    tick(6);  lit("mid_pre", int'(EN), 4'b0011);
    do_reset();
    tick(1);  lit("mid_restart", int'(EN), 4'b0001);
    tick(4);  lit("mid_e5", int'(EN), 4'b0011);
    // no-op
    REQ = 4'b0000;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1);
      lit("noop_en", int'(EN), 0);
      lit("noop_busy", int'(BUSY), 0);
      lit("noop_done", int'(DONE), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clkbuf_enable_sequencer.md
# clkbuf_enable_sequencer

Staged enable controller for up to N gated clock-buffer branches (each branch is an ICG driving a `clkbuf_*` tree). It walks the registered branch-enable vector toward a requested vector one bit at a time. Successive changes are separated by a programmable quiet gap, which bounds supply di/dt when large clock trees start or stop. It sits in the always-on clock-control domain, clocked by the root clock that feeds the ICGs.

## Interface
Parameters:
- `N`, 4: number of clock branches (1–32).
- `GAP`, 3: quiet cycles after each enable change (1–255). Counter width is `$clog2(GAP+1)`.

Ports:
- `CLK`  input  1  root clock; all state updates on the rising edge.
- `RN`  input  1  asynchronous active-low reset.
- `REQ`  input  N  requested branch enables; synchronous to `CLK` and may change on any cycle.
- `HOLD`  input  1  while high, no new toggle is started; an in-progress gap keeps counting.
- `EN`  output  N  registered branch enables driven to the ICG enable pins.
- `BUSY`  output  1  combinational: `(state==WAIT) | (REQ != EN)`.
- `DONE`  output  1  registered one-cycle pulse when the sequence completes.

## Operation
- The FSM has two states, IDLE and WAIT. It also has a gap counter `cnt`.
- **IDLE**, at each edge:
  - If `HOLD`=0 and `REQ != EN`, select one branch to toggle and invert `EN[i]`.
  - On the same edge, load `cnt` with `GAP` and move to WAIT.
  - Otherwise remain in IDLE with `EN` unchanged.
- **Selection priority:**
  - Disables (`EN[i]=1`, `REQ[i]=0`) win over enables.
  - Within a class, the lowest index wins.
  - Exactly one bit of `EN` changes per toggle edge.
- **WAIT**, at each edge:
  - If `cnt==1`, go to IDLE.
  - Otherwise decrement `cnt`.
  - `EN` is frozen throughout WAIT.
- **DONE** is set on the edge where WAIT goes to IDLE, if `REQ==EN` at that edge. It clears on the following edge.
- **REQ changes:**
  - A `REQ` change during WAIT has no effect until the next IDLE evaluation.
  - A bit whose request reverts before it is selected is never toggled.
- **HOLD:**
  - Ignored in WAIT.
  - In IDLE it blocks toggles; `BUSY` still reflects any mismatch.
- **Reset:** `RN`=0 forces `EN`=0, state=IDLE, `cnt`=0 and `DONE`=0 immediately, independent of `CLK`. A sequence interrupted mid-operation is abandoned. There is no glitch on `EN` other than the asynchronous clear.

## Timing
- **Reset values:** `EN`=0, `DONE`=0. `BUSY` = `(REQ != 0)`.
- **First toggle:** occurs at the first rising edge after `RN` deasserts, if `REQ != EN` at that edge.
- **Toggle spacing:** toggle edges are exactly `GAP+1` edges apart while a mismatch persists and `HOLD`=0.
- **Total length:** k mismatched bits complete in `k*(GAP+1)` edges. `DONE` is high for the cycle after the final WAIT-to-IDLE edge.
- **Latency:** the `REQ` to `EN` latency for the first change is one edge from IDLE. From WAIT it is up to `GAP+1` edges.
- **Idle behaviour:** no toggle and no `DONE` when `REQ==EN` in IDLE.
- **Reset timing:** `RN` release must meet recovery time to `CLK`. A reset-synchronizer stage is external.

## Test plan
All scenarios use `N`=4, `GAP`=3; edge numbers count from `RN` release.

- **Full power-up sequence:** `REQ`=1111 held from reset.
  - `EN` = 0001 at edge 1, 0011 at edge 5, 0111 at edge 9, 1111 at edge 13.
  - `DONE` is high for exactly the cycle after edge 16.
  - `BUSY` is low after edge 16.
- **Disable priority:** with `EN`=0011 settled, set `REQ`=1100.
  - The first toggle clears bit 0 (`EN`=0010).
  - Then bit 1 clears (`EN`=0000), then bit 2 sets (0100), then bit 3 sets (1100), each 4 edges apart.
  - One `DONE` pulse follows the last toggle.
- **Request reverts:** `REQ`=0011 from `EN`=0000. During the WAIT after bit 0 is set, change `REQ` to 0001.
  - No further toggle occurs.
  - `DONE` pulses on the WAIT-to-IDLE edge.
  - `EN` stays 0001.
- **HOLD:** assert `HOLD` in IDLE with `REQ`=0001, `EN`=0000, for 10 cycles.
  - `EN` stays 0000 and `BUSY`=1 throughout.
  - After `HOLD` drops, bit 0 sets on the next edge.
- **Reset mid-sequence:** pulse `RN` low between edges 6 and 7 of scenario 1.
  - `EN`=0000 and `DONE`=0 asynchronously.
  - After release the sequence restarts: `EN`=0001 at the first edge.
- **No-op:** `REQ`=0000 after reset for 20 cycles.
  - `EN`=0000, `BUSY`=0 and `DONE`=0 throughout.
